// File: rtl/ha_resp_checker.sv
// Response checker for half-adder style DUTs: accepts {A,B,SUM,CARRY} samples over
// valid/ready, grades them against A^B / A&B, and tracks pass/fail, first error and coverage.
module ha_resp_checker #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic             A,
    input  logic             B,
    input  logic             SUM,
    input  logic             CARRY,
    output logic             in_ready,
    output logic             busy,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       cov,
    output logic             err_seen,
    output logic [3:0]       first_err_vec,
    output logic             done,
    output logic             timeout
);

    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_TOUT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDLE_W-1:0] idle_cnt;
    logic              accept;
    logic              match;
    logic [3:0]        sample_bit;
    logic [3:0]        cov_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic golden_match(input logic a, input logic b,
                                          input logic s, input logic c);
        return (s == (a ^ b)) && (c == (a & b));
    endfunction

    assign accept     = in_valid & in_ready;
    assign match      = golden_match(A, B, SUM, CARRY);
    assign sample_bit = 4'b0001 << {A, B};
    assign cov_next   = cov | sample_bit;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    if (cov_next == 4'hF) state_next = S_DONE;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next = S_TOUT;
                end
            end
            S_DONE:  done    = 1'b1;
            S_TOUT:  timeout = 1'b1;
            default: state_next = state;
        endcase
        // start overrides everything, including an accept in the same cycle
        if (start) state_next = S_RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            cov           <= '0;
            err_seen      <= 1'b0;
            first_err_vec <= '0;
            idle_cnt      <= '0;
        end else if (start) begin
            pass_cnt      <= '0;
            fail_cnt      <= '0;
            cov           <= '0;
            err_seen      <= 1'b0;
            first_err_vec <= '0;
            idle_cnt      <= '0;
        end else if (accept) begin
            if (match) begin
                pass_cnt <= sat_inc(pass_cnt);
            end else begin
                fail_cnt <= sat_inc(fail_cnt);
                if (!err_seen) begin
                    first_err_vec <= {A, B, SUM, CARRY};
                    err_seen      <= 1'b1;
                end
            end
            cov      <= cov_next;
            idle_cnt <= '0;
        end else if (state == S_RUN) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

endmodule

// File: tb/tb_ha_resp_checker.sv
// Bench for ha_resp_checker: two instances (wide and 2-bit counters) share stimulus and are
// graded every cycle against a sample-history model, plus literal spot checks per scenario.
module tb_ha_resp_checker;

    localparam int TOUT_CYC = 16;
    localparam int MAX_B = 255;
    localparam int MAX_S = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_TOUT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, A = 1'b0, B = 1'b0, SUM = 1'b0, CARRY = 1'b0;

    logic       rdy_b, busy_b, err_b, done_b, to_b;
    logic [7:0] pass_b, fail_b;
    logic [3:0] cov_b, fev_b;
    logic       rdy_s, busy_s, err_s, done_s, to_s;
    logic [1:0] pass_s, fail_s;
    logic [3:0] cov_s, fev_s;

    int n_checks = 0;
    int n_fail = 0;

    // model: plain history statistics, counts kept unbounded and clipped on compare
    int       m_mode = M_IDLE;
    int       m_pass = 0, m_fail = 0, m_quiet = 0;
    logic [3:0] m_cov = '0, m_first = '0;
    logic     m_err = 1'b0;

    ha_resp_checker #(.CNT_W(8), .TIMEOUT(TOUT_CYC)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .A(A), .B(B), .SUM(SUM), .CARRY(CARRY),
        .in_ready(rdy_b), .busy(busy_b), .pass_cnt(pass_b), .fail_cnt(fail_b),
        .cov(cov_b), .err_seen(err_b), .first_err_vec(fev_b), .done(done_b), .timeout(to_b)
    );

    ha_resp_checker #(.CNT_W(2), .TIMEOUT(TOUT_CYC)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .A(A), .B(B), .SUM(SUM), .CARRY(CARRY),
        .in_ready(rdy_s), .busy(busy_s), .pass_cnt(pass_s), .fail_cnt(fail_s),
        .cov(cov_s), .err_seen(err_s), .first_err_vec(fev_s), .done(done_s), .timeout(to_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_IDLE; m_pass = 0; m_fail = 0; m_quiet = 0;
                m_cov = '0; m_first = '0; m_err = 1'b0;
            end else if (start) begin
                m_mode = M_RUN; m_pass = 0; m_fail = 0; m_quiet = 0;
                m_cov = '0; m_first = '0; m_err = 1'b0;
            end else if (m_mode == M_RUN) begin
                if (in_valid) begin
                    int total;
                    int idx;
                    total = int'(A) + int'(B);
                    idx = 2 * int'(A) + int'(B);
                    if (int'(SUM) == total % 2 && int'(CARRY) == total / 2) begin
                        m_pass++;
                    end else begin
                        m_fail++;
                        if (!m_err) begin
                            m_first = {A, B, SUM, CARRY};
                            m_err = 1'b1;
                        end
                    end
                    m_cov[idx] = 1'b1;
                    m_quiet = 0;
                    if (m_cov == 4'hF) m_mode = M_DONE;
                end else begin
                    m_quiet++;
                    if (m_quiet >= TOUT_CYC) m_mode = M_TOUT;
                end
            end
        end
    end

    task automatic cmp_inst(input string tag, input logic rdy, input logic bsy,
                            input logic [7:0] pc, input logic [7:0] fc, input logic [3:0] cv,
                            input logic es, input logic [3:0] fev, input logic dn,
                            input logic to, input int maxc);
        int ep, ef;
        ep = (m_pass > maxc) ? maxc : m_pass;
        ef = (m_fail > maxc) ? maxc : m_fail;
        chk({tag, "_in_ready"}, 32'(rdy), 32'(m_mode == M_RUN));
        chk({tag, "_busy"}, 32'(bsy), 32'(m_mode == M_RUN));
        chk({tag, "_pass_cnt"}, 32'(pc), 32'(ep));
        chk({tag, "_fail_cnt"}, 32'(fc), 32'(ef));
        chk({tag, "_cov"}, 32'(cv), 32'(m_cov));
        chk({tag, "_err_seen"}, 32'(es), 32'(m_err));
        chk({tag, "_first_err_vec"}, 32'(fev), 32'(m_first));
        chk({tag, "_done"}, 32'(dn), 32'(m_mode == M_DONE));
        chk({tag, "_timeout"}, 32'(to), 32'(m_mode == M_TOUT));
    endtask

    always @(negedge clk) begin
        cmp_inst("big", rdy_b, busy_b, pass_b, fail_b, cov_b, err_b, fev_b, done_b, to_b, MAX_B);
        cmp_inst("small", rdy_s, busy_s, {6'd0, pass_s}, {6'd0, fail_s}, cov_s, err_s, fev_s,
                 done_s, to_s, MAX_S);
    end

    task automatic drive(input logic v, input logic [1:0] ab, input logic [1:0] sc,
                         input logic st);
        @(negedge clk);
        in_valid = v; A = ab[1]; B = ab[0]; SUM = sc[1]; CARRY = sc[0]; start = st;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic pulse_start();
        drive(1'b0, 2'b00, 2'b00, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #12;
        chk("rst_pass", 32'(pass_b), 0);
        chk("rst_busy", 32'(busy_b), 0);
        chk("rst_ready", 32'(rdy_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: all four correct vectors
        pulse_start();
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 2'b01, 2'b10, 1'b0);
        drive(1'b1, 2'b10, 2'b10, 1'b0);
        drive(1'b1, 2'b11, 2'b01, 1'b0);
        idle();
        chk("t1_pass", 32'(pass_b), 4);
        chk("t1_pass_small", 32'(pass_s), 3);
        chk("t1_fail", 32'(fail_b), 0);
        chk("t1_cov", 32'(cov_b), 32'hF);
        chk("t1_err", 32'(err_b), 0);
        chk("t1_done", 32'(done_b), 1);
        chk("t1_ready", 32'(rdy_b), 0);

        // 2: two mismatches, first one sticks
        pulse_start();
        drive(1'b1, 2'b11, 2'b11, 1'b0);
        drive(1'b1, 2'b01, 2'b00, 1'b0);
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 2'b10, 2'b10, 1'b0);
        idle();
        chk("t2_fail", 32'(fail_b), 2);
        chk("t2_pass", 32'(pass_b), 2);
        chk("t2_first", 32'(fev_b), 32'hF);
        chk("t2_err", 32'(err_b), 1);
        chk("t2_done", 32'(done_b), 1);

        // 3: stall into timeout, then restart
        pulse_start();
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        repeat (TOUT_CYC) idle();
        chk("t3_not_yet", 32'(to_b), 0);
        idle();
        chk("t3_timeout", 32'(to_b), 1);
        chk("t3_cov", 32'(cov_b), 32'h1);
        chk("t3_pass", 32'(pass_b), 1);
        pulse_start();
        idle();
        chk("t3_busy", 32'(busy_b), 1);
        chk("t3_cleared_pass", 32'(pass_b), 0);
        chk("t3_cleared_cov", 32'(cov_b), 0);

        // 4: saturation on the 2-bit instance
        repeat (6) drive(1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 2'b01, 2'b10, 1'b0);
        drive(1'b1, 2'b10, 2'b10, 1'b0);
        drive(1'b1, 2'b11, 2'b01, 1'b0);
        idle();
        chk("t4_pass_small", 32'(pass_s), 3);
        chk("t4_pass_big", 32'(pass_b), 9);
        chk("t4_cov", 32'(cov_s), 32'hF);
        chk("t4_done", 32'(done_s), 1);

        // 5: start collides with a mismatching sample
        pulse_start();
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 2'b10, 2'b00, 1'b1);
        idle();
        chk("t5_fail", 32'(fail_b), 0);
        chk("t5_err", 32'(err_b), 0);
        chk("t5_cov", 32'(cov_b), 0);
        chk("t5_pass", 32'(pass_b), 0);
        chk("t5_busy", 32'(busy_b), 1);

        // 6: asynchronous reset mid-run
        drive(1'b1, 2'b00, 2'b00, 1'b0);
        drive(1'b1, 2'b01, 2'b10, 1'b0);
        idle();
        chk("t6_pre_pass", 32'(pass_b), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pass", 32'(pass_b), 0);
        chk("t6_cov", 32'(cov_b), 0);
        chk("t6_busy", 32'(busy_b), 0);
        chk("t6_ready", 32'(rdy_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b11, 2'b00, 1'b0);
        drive(1'b1, 2'b01, 2'b10, 1'b0);
        idle();
        chk("t6_ignored_pass", 32'(pass_b), 0);
        chk("t6_ignored_fail", 32'(fail_b), 0);
        chk("t6_ignored_cov", 32'(cov_b), 0);
        chk("t6_idle_busy", 32'(busy_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ha_resp_checker.md
Name: ha_resp_checker

Overview:
- Synthesizable response checker for half-adder style DUTs; the receiving end of the A/B stimulus sequence.
- Samples input vectors {A,B} and DUT outputs {SUM,CARRY} over a valid/ready handshake.
- Compares each sample against the golden model, counts passes and fails, and latches the first mismatch.
- Tracks coverage of all four input combinations and flags completion or stall (timeout). Sits beside the DUT in on-chip self-test and in the team's regression benches.

Parameters:
CNT_W, 8, width of pass/fail counters (saturating)
TIMEOUT, 16, consecutive RUN cycles without an accepted sample before entering TOUT (minimum 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: clear statistics, enter RUN
in_valid  input  1  sample presented this cycle
A  input  1  stimulus operand A as applied to DUT
B  input  1  stimulus operand B as applied to DUT
SUM  input  1  DUT sum output
CARRY  input  1  DUT carry output
in_ready  output  1  checker accepts samples (high only in RUN)
busy  output  1  state == RUN
pass_cnt  output  CNT_W  matching samples
fail_cnt  output  CNT_W  mismatching samples
cov  output  4  bit {A,B} set once that combination has been accepted
err_seen  output  1  at least one mismatch since start
first_err_vec  output  4  {A,B,SUM,CARRY} of first mismatch
done  output  1  state == DONE
timeout  output  1  state == TOUT

Behaviour:
- Reset (async on rst_n low, released synchronously to clk): state IDLE; all outputs 0; internal idle counter 0.
- States:
  - IDLE: start -> RUN.
  - RUN: on accept, if (cov | onehot({A,B})) == 4'hF -> DONE; else if idle counter reaches TIMEOUT-1 with no accept -> TOUT.
  - DONE and TOUT: hold all outputs; start -> RUN.
- Accept = in_valid & in_ready. in_ready = (state == RUN), decoded combinationally from state. Samples offered while not RUN are ignored; no backpressure within RUN.
- Golden model: expected SUM = A ^ B; expected CARRY = A & B. Match requires both bits equal.
- Latency: counters, cov, err_seen and first_err_vec update on the accept edge and are visible the following cycle. done/timeout assert the cycle after the causing edge.
- Mismatch handling: fail_cnt++. If err_seen == 0, latch first_err_vec = {A,B,SUM,CARRY} and set err_seen. Later mismatches never overwrite first_err_vec.
- Match handling: pass_cnt++.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Coverage counts the accepted input combination regardless of pass/fail. Completion depends on coverage only, not on correctness: a failing run still reaches DONE, with err_seen flagging the failure.
- Idle counter: cleared on start and on each accept; increments each RUN cycle without accept.
- start (any state, including RUN) clears pass_cnt, fail_cnt, cov, err_seen, first_err_vec and the idle counter, then enters RUN. start and a valid sample in the same cycle: start wins and the sample is discarded.
- Repeated vectors are counted in pass/fail every time; cov is idempotent.
- Reset mid-run: immediate return to IDLE with all statistics cleared. No partial results are retained.

Test Plan:
1. Reset, start, then apply correct vectors 00/0,0; 01/1,0; 10/1,0; 11/0,1 on consecutive cycles -> pass_cnt=4, fail_cnt=0, cov=4'hF, err_seen=0; done=1 one cycle after the 4th accept; in_ready=0 afterwards.
2. Apply 11 with SUM=1,CARRY=1, then 01 with SUM=0,CARRY=0, then the remaining correct vectors -> fail_cnt=2, pass_cnt=2, first_err_vec=4'b1111 (not overwritten by the second mismatch), err_seen=1, done=1.
3. Start, apply 00 correct, then hold in_valid low for TIMEOUT cycles -> timeout=1, cov=4'b0001, pass_cnt=1; a further start clears all statistics and re-enters RUN (busy=1).
4. With CNT_W=2, apply 00 correct six times, then 01/10/11 correct -> pass_cnt saturates at 3 and stays 3; cov=4'hF; done=1.
5. Assert start in the same cycle as a valid mismatching 10 sample mid-run -> sample discarded: fail_cnt=0, err_seen=0, cov=0, busy=1.
6. Drop rst_n low asynchronously mid-run after 2 accepts -> all outputs 0 immediately, state IDLE; in_valid samples ignored until the next start.
